qos_pcie_nch: RTL and testbench

Parametrised N-channel QoS dispatcher for the PCIe QoS path. Incoming words are steered by their class field into one of NUM_CH first-word-fall-through class FIFOs. Programmable almost-full and almost-empty thresholds drive per-channel backpressure. The block adds per-channel pop counters, a drop counter and a sticky ERROR state, which the 4-channel fixed version lacks.

---
 rtl/qos_pcie_nch.sv | 177 +++++++++++++++++
 tb/tb_qos_pcie_nch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/qos_pcie_nch.sv
// N-channel QoS dispatcher: class-steered FWFT FIFOs with programmable
// almost-full/almost-empty thresholds, pop/drop statistics and a sticky error state.
module qos_pcie_nch #(
    parameter int DATA_WIDTH   = 12,
    parameter int NUM_CH       = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int UMB_WIDTH    = 4,
    parameter int UMB_HIGH_DEF = 6,
    parameter int UMB_LOW_DEF  = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             init,
    input  logic [UMB_WIDTH-1:0]             umbral_high,
    input  logic [UMB_WIDTH-1:0]             umbral_low,
    input  logic                             push,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [NUM_CH-1:0]                pop,
    output logic [NUM_CH*DATA_WIDTH-1:0]     data_out,
    output logic [NUM_CH-1:0]                empty,
    output logic [NUM_CH-1:0]                almost_full,
    output logic [NUM_CH-1:0]                almost_empty,
    output logic                             pause,
    input  logic                             req,
    input  logic [$clog2(NUM_CH+1)-1:0]      idx,
    output logic                             valid,
    output logic [CNT_WIDTH-1:0]             data,
    output logic                             active_out,
    output logic                             idle_out,
    output logic                             error_out
);

    localparam int CLS_W = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(NUM_CH + 1);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic [1:0]                  state_reg, state_next;
    logic [UMB_WIDTH-1:0]        umb_high_reg, umb_low_reg;
    logic [CNT_WIDTH-1:0]        drop_cnt_reg;
    logic                        valid_reg;
    logic [CNT_WIDTH-1:0]        data_reg;
    logic [CLS_W-1:0]            ch;
    logic [NUM_CH-1:0]           full, push_ok, pop_ok;
    logic                        accept, drop, thr_valid;
    logic [NUM_CH*CNT_WIDTH-1:0] pop_cnt_flat;
    logic [CNT_WIDTH-1:0]        rd_sel;

    assign ch = data_in[DATA_WIDTH-1 -: CLS_W];
    // A full target still accepts when its head leaves in the same cycle.
    assign accept = push && (state_reg != ST_INIT) && (!full[ch] || pop[ch]);
    assign drop   = push && !accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
            logic [CNT_W-1:0]      count_reg;
            logic [CNT_WIDTH-1:0]  pop_cnt_reg;

            assign empty[gi]        = (count_reg == '0);
            assign full[gi]         = (count_reg == CNT_W'(FIFO_DEPTH));
            assign push_ok[gi]      = accept && (ch == CLS_W'(gi));
            assign pop_ok[gi]       = pop[gi] && !empty[gi];
            assign almost_full[gi]  = (UMB_WIDTH'(count_reg) >= umb_high_reg);
            assign almost_empty[gi] = (UMB_WIDTH'(count_reg) <= umb_low_reg);
            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = empty[gi] ? '0 : mem[rd_ptr_reg];
            assign pop_cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = pop_cnt_reg;

            always_ff @(posedge clk) begin
                if (push_ok[gi])
                    mem[wr_ptr_reg] <= data_in;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg  <= '0;
                    rd_ptr_reg  <= '0;
                    count_reg   <= '0;
                    pop_cnt_reg <= '0;
                end else begin
                    if (push_ok[gi])
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop_ok[gi]) begin
                        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
                        pop_cnt_reg <= pop_cnt_reg + CNT_WIDTH'(1);
                    end
                    case ({push_ok[gi], pop_ok[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign thr_valid = (umbral_low < umbral_high) &&
                       (umbral_high <= UMB_WIDTH'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            umb_high_reg <= UMB_WIDTH'(UMB_HIGH_DEF);
            umb_low_reg  <= UMB_WIDTH'(UMB_LOW_DEF);
        end else if (state_reg == ST_INIT && init && thr_valid) begin
            umb_high_reg <= umbral_high;
            umb_low_reg  <= umbral_low;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt_reg <= '0;
        else if (drop && drop_cnt_reg != '1)
            drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
    end

    // A drop outranks init so the error stays visible.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:   if (!init) state_next = ST_IDLE;
            ST_IDLE: begin
                if (drop)        state_next = ST_ERROR;
                else if (init)   state_next = ST_INIT;
                else if (accept) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (drop)                state_next = ST_ERROR;
                else if (init)           state_next = ST_INIT;
                else if (&empty && !push) state_next = ST_IDLE;
            end
            default:   state_next = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= ST_INIT;
        else
            state_reg <= state_next;
    end

    always_comb begin
        rd_sel = '0;
        if (idx == IDX_W'(NUM_CH))
            rd_sel = drop_cnt_reg;
        for (int k = 0; k < NUM_CH; k++)
            if (idx == IDX_W'(k))
                rd_sel = pop_cnt_flat[k*CNT_WIDTH +: CNT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            valid_reg <= req;
            data_reg  <= req ? rd_sel : '0;
        end
    end

    assign valid      = valid_reg;
    assign data       = data_reg;
    assign pause      = |almost_full;
    assign active_out = (state_reg == ST_ACTIVE);
    assign idle_out   = (state_reg == ST_IDLE);
    assign error_out  = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_qos_pcie_nch.sv
// Directed bench for qos_pcie_nch: hand-computed expectations for thresholds,
// dispatch, backpressure, drops, counter reads and reset.
module tb_qos_pcie_nch;

    logic        clk = 1'b0;
    logic        reset, init, push, req;
    logic [3:0]  umbral_high, umbral_low;
    logic [11:0] data_in;
    logic [3:0]  pop;
    logic [2:0]  idx;
    logic [47:0] data_out;
    logic [3:0]  empty, almost_full, almost_empty;
    logic        pause, valid, active_out, idle_out, error_out;
    logic [7:0]  data;

    int n_vec = 0;
    int n_bad = 0;

    qos_pcie_nch dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_high(umbral_high), .umbral_low(umbral_low),
        .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .pause(pause), .req(req), .idx(idx), .valid(valid), .data(data),
        .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    function automatic logic [11:0] head(input int k);
        return data_out[k*12 +: 12];
    endfunction

    task automatic do_push(input logic [11:0] w);
        push = 1'b1; data_in = w;
        tick();
        push = 1'b0;
    endtask

    task automatic rd(input logic [2:0] i, input logic [7:0] exp, input string tag);
        req = 1'b1; idx = i;
        tick();
        req = 1'b0;
        chk({tag, "_valid"}, 64'(valid), 64'd1);
        chk(tag, 64'(data), 64'(exp));
    endtask

    initial begin
        logic [11:0] fill [5];
        fill[0] = 12'h066; fill[1] = 12'h077; fill[2] = 12'h088;
        fill[3] = 12'h099; fill[4] = 12'h0AA;

        reset = 1'b1; init = 1'b0; push = 1'b0; req = 1'b0;
        umbral_high = '0; umbral_low = '0; data_in = '0; pop = '0; idx = '0;
        tick(); tick();
        chk("rst_empty", 64'(empty), 64'hF);
        chk("rst_aempty", 64'(almost_empty), 64'hF);
        chk("rst_afull", 64'(almost_full), 64'h0);
        chk("rst_pause", 64'(pause), 64'h0);
        chk("rst_dout", 64'(data_out), 64'h0);
        chk("rst_state", 64'({active_out, idle_out, error_out, valid}), 64'h0);
        chk("rst_data", 64'(data), 64'h0);

        // thresholds: 7/2 then 5/1 are valid, 3/3 later is rejected
        reset = 1'b0; init = 1'b1; umbral_high = 4'd7; umbral_low = 4'd2;
        tick();
        umbral_high = 4'd5; umbral_low = 4'd1;
        tick();
        init = 1'b0;
        tick();
        chk("t1_idle", 64'(idle_out), 64'd1);
        init = 1'b1; umbral_high = 4'd3; umbral_low = 4'd3;
        tick(); tick();
        chk("t1_in_init", 64'({active_out, idle_out, error_out}), 64'h0);
        init = 1'b0;
        tick();
        chk("t1_idle2", 64'(idle_out), 64'd1);

        // one word per class
        do_push(12'h0FF); do_push(12'h404); do_push(12'h895); do_push(12'hCAE);
        chk("t2_active", 64'(active_out), 64'd1);
        chk("t2_empty", 64'(empty), 64'h0);
        chk("t2_dout", 64'(data_out), 64'hCAE8954040FF);
        chk("t2_head0", 64'(head(0)), 64'h0FF);
        pop = 4'hF;
        tick();
        pop = 4'h0;
        tick();
        chk("t2_idle", 64'(idle_out), 64'd1);
        chk("t2_empty_all", 64'(empty), 64'hF);
        for (int k = 0; k < 4; k++)
            rd(3'(k), 8'd1, $sformatf("t2_popcnt%0d", k));

        // thresholds 5/1 on channel 0
        for (int k = 0; k < 5; k++) begin
            do_push(fill[k]);
            chk($sformatf("t3_aempty_%0d", k + 1), 64'(almost_empty[0]), 64'(k < 1));
            chk($sformatf("t3_afull_%0d", k + 1), 64'(almost_full[0]), 64'(k >= 4));
            chk($sformatf("t3_pause_%0d", k + 1), 64'(pause), 64'(k >= 4));
        end
        chk("t3_head", 64'(head(0)), 64'h066);

        // fill to 8, full push with pop accepted, then a real drop
        do_push(12'h0BB); do_push(12'h0CC); do_push(12'h0DD);
        push = 1'b1; data_in = 12'h0EE; pop = 4'b0001;
        tick();
        push = 1'b0; pop = 4'h0;
        chk("t4_head_after_pp", 64'(head(0)), 64'h077);
        chk("t4_no_error", 64'(error_out), 64'd0);
        rd(3'd4, 8'd0, "t4_drop0");
        do_push(12'h0F1);
        chk("t4_error", 64'(error_out), 64'd1);
        chk("t4_head_kept", 64'(head(0)), 64'h077);
        chk("t4_afull", 64'(almost_full[0]), 64'd1);
        rd(3'd4, 8'd1, "t4_drop1");

        // counter reads, incl. read concurrent with increment
        pop = 4'b0001; tick(); tick();
        chk("t5_head", 64'(head(0)), 64'h099);
        req = 1'b1; idx = 3'd0;
        tick();
        req = 1'b0; pop = 4'h0;
        chk("t5_pre_inc", 64'(data), 64'd4);
        chk("t5_head2", 64'(head(0)), 64'h0AA);
        rd(3'd0, 8'd5, "t5_popcnt0");
        rd(3'd4, 8'd1, "t5_drop");
        rd(3'd5, 8'd0, "t5_idx5");
        rd(3'd7, 8'd0, "t5_idx7");
        pop = 4'b0010; tick(); pop = 4'h0;
        rd(3'd1, 8'd1, "t5_pop_empty");
        tick();
        chk("t5_noreq", 64'({valid, data}), 64'h0);
        chk("t5_error_sticky", 64'(error_out), 64'd1);

        // reset out of ERROR with data queued, then a push in INIT
        reset = 1'b1;
        tick();
        chk("t6_empty", 64'(empty), 64'hF);
        chk("t6_dout", 64'(data_out), 64'h0);
        chk("t6_state", 64'({active_out, idle_out, error_out}), 64'h0);
        reset = 1'b0;
        do_push(12'h811);
        chk("t6_init_push", 64'(empty), 64'hF);
        chk("t6_init_noerr", 64'({idle_out, error_out}), 64'h2);
        rd(3'd4, 8'd1, "t6_drop_init");
        rd(3'd0, 8'd0, "t6_popcnt0_clr");

        do_push(12'h811); do_push(12'h822); do_push(12'h833);
        chk("t6_active", 64'(active_out), 64'd1);
        chk("t6_head2", 64'(head(2)), 64'h811);
        pop = 4'b0100; tick(); tick(); tick(); pop = 4'h0;
        rd(3'd2, 8'd3, "t6_popcnt2");
        do_push(12'h844); do_push(12'h855);
        chk("t6_active2", 64'(active_out), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_empty", 64'(empty), 64'hF);
        chk("t6_rst_state", 64'({active_out, idle_out, error_out}), 64'h0);
        chk("t6_rst_dout", 64'(data_out), 64'h0);
        rd(3'd2, 8'd0, "t6_popcnt2_clr");
        rd(3'd4, 8'd0, "t6_drop_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
